// File: rtl/seq101_detector.sv
// rtl/seq101_detector.sv - overlapping Moore "101" detector with clock-enable divider
module seq101_detector #(
    parameter int CLK_DIV = 1
) (
    input  logic       mclk,
    input  logic       reset,
    output logic       clk,
    input  logic       x,
    output logic       y,
    output logic [1:0] state
);

    localparam logic [1:0] S0 = 2'b00;  // no prefix
    localparam logic [1:0] S1 = 2'b01;  // seen "1"
    localparam logic [1:0] S2 = 2'b10;  // seen "10"
    localparam logic [1:0] S3 = 2'b11;  // seen "101"

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_clk;
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          w_tick;

    // With CLK_DIV=1 the counter is pinned at 0 so tick is constantly high.
    assign w_tick = (r_cnt == CNT_LAST);

    // Step divider: count 0..CLK_DIV-1 and wrap on tick.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Registered step pulse, exported for debug only.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_clk <= 1'b0;
        end else begin
            r_clk <= w_tick;
        end
    end

    // Next-state decode; S3 falls back onto S1/S2 so matches can overlap.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S0:      w_state_next = x ? S1 : S0;
            S1:      w_state_next = x ? S1 : S2;
            S2:      w_state_next = x ? S3 : S0;
            S3:      w_state_next = x ? S1 : S2;
            default: w_state_next = S0;
        endcase
    end

    // State register advances only on step edges; reset wins over tick.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state <= S0;
        end else if (w_tick) begin
            r_state <= w_state_next;
        end
    end

    assign clk   = r_clk;
    assign state = r_state;
    assign y     = r_state[1] & r_state[0];

endmodule

// File: tb/tb_seq101_detector.sv
// tb/tb_seq101_detector.sv - directed bench for seq101_detector at CLK_DIV=1 and CLK_DIV=4
module tb_seq101_detector;

    logic       mclk;
    logic       reset1, x1, clk1, y1;
    logic [1:0] state1;
    logic       reset4, x4, clk4, y4;
    logic [1:0] state4;

    int total;
    int bad;

    seq101_detector #(.CLK_DIV(1)) dut1 (
        .mclk (mclk),
        .reset(reset1),
        .clk  (clk1),
        .x    (x1),
        .y    (y1),
        .state(state1)
    );

    seq101_detector #(.CLK_DIV(4)) dut4 (
        .mclk (mclk),
        .reset(reset4),
        .clk  (clk4),
        .x    (x4),
        .y    (y4),
        .state(state4)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Drive one bit into dut1 and advance one edge; sample 1 time unit after.
    task automatic step1(input logic b);
        x1 = b;
        @(posedge mclk);
        #1;
    endtask

    task automatic test_reset;
        reset1 = 1'b1;
        x1     = 1'b1;
        @(posedge mclk);
        #1;
        total++;
        if (state1 !== 2'b00) begin
            bad++;
            $display("FAIL reset_state1 got=%b want=00", state1);
        end
        total++;
        if (y1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_y1 got=%b want=0", y1);
        end
        total++;
        if (clk1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_clk1 got=%b want=0", clk1);
        end
        x1 = 1'b0;
        @(posedge mclk);
        #1;
        total++;
        if (state1 !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold_state1 got=%b want=00", state1);
        end
        total++;
        if (clk1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold_clk1 got=%b want=0", clk1);
        end
        reset1 = 1'b0;
    endtask

    task automatic test_basic_detect;
        logic       xs [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] es [5]  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic       eys [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            step1(xs[i]);
            total++;
            if (state1 !== es[i]) begin
                bad++;
                $display("FAIL basic_state[%0d] got=%b want=%b", i, state1, es[i]);
            end
            total++;
            if (y1 !== eys[i]) begin
                bad++;
                $display("FAIL basic_y[%0d] got=%b want=%b", i, y1, eys[i]);
            end
            total++;
            if (clk1 !== 1'b1) begin
                bad++;
                $display("FAIL basic_clk[%0d] got=%b want=1", i, clk1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic       xs [8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] es [8]  = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11};
        logic       eys [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step1(xs[i]);
            total++;
            if (state1 !== es[i]) begin
                bad++;
                $display("FAIL overlap_state[%0d] got=%b want=%b", i, state1, es[i]);
            end
            total++;
            if (y1 !== eys[i]) begin
                bad++;
                $display("FAIL overlap_y[%0d] got=%b want=%b", i, y1, eys[i]);
            end
        end
    endtask

    task automatic test_non_patterns;
        logic       xs [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0] es [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
        for (int i = 0; i < 8; i++) begin
            step1(xs[i]);
            total++;
            if (state1 !== es[i]) begin
                bad++;
                $display("FAIL nonpat_state[%0d] got=%b want=%b", i, state1, es[i]);
            end
            total++;
            if (y1 !== 1'b0) begin
                bad++;
                $display("FAIL nonpat_y[%0d] got=%b want=0", i, y1);
            end
        end
    endtask

    task automatic test_mid_reset;
        step1(1'b1);
        step1(1'b0);
        total++;
        if (state1 !== 2'b10) begin
            bad++;
            $display("FAIL midrst_pre_state got=%b want=10", state1);
        end
        reset1 = 1'b1;
        step1(1'b1);
        total++;
        if (state1 !== 2'b00) begin
            bad++;
            $display("FAIL midrst_state got=%b want=00", state1);
        end
        reset1 = 1'b0;
        step1(1'b1);
        total++;
        if (state1 !== 2'b01 || y1 !== 1'b0) begin
            bad++;
            $display("FAIL midrst_after1 got=%b/%b want=01/0", state1, y1);
        end
        step1(1'b0);
        step1(1'b1);
        total++;
        if (state1 !== 2'b11 || y1 !== 1'b1) begin
            bad++;
            $display("FAIL midrst_detect got=%b/%b want=11/1", state1, y1);
        end
    endtask

    task automatic test_divider;
        logic [2:0] bits = 3'b101;
        logic [1:0] exp_state;
        int         y_cycles;
        int         clk_pulses;
        reset4 = 1'b1;
        x4     = 1'b0;
        @(posedge mclk);
        #1;
        total++;
        if (state4 !== 2'b00 || clk4 !== 1'b0 || y4 !== 1'b0) begin
            bad++;
            $display("FAIL div_reset got=%b/%b/%b want=00/0/0", state4, clk4, y4);
        end
        reset4     = 1'b0;
        y_cycles   = 0;
        clk_pulses = 0;
        for (int e = 1; e <= 16; e++) begin
            // Bits 1,0,1 held for 4 cycles each, then 0.
            if (e <= 12) x4 = bits[2 - (e - 1) / 4];
            else         x4 = 1'b0;
            @(posedge mclk);
            #1;
            if      (e < 4)  exp_state = 2'b00;
            else if (e < 8)  exp_state = 2'b01;
            else if (e < 12) exp_state = 2'b10;
            else if (e < 16) exp_state = 2'b11;
            else             exp_state = 2'b10;
            total++;
            if (state4 !== exp_state) begin
                bad++;
                $display("FAIL div_state[%0d] got=%b want=%b", e, state4, exp_state);
            end
            total++;
            if (clk4 !== ((e % 4) == 0)) begin
                bad++;
                $display("FAIL div_clk[%0d] got=%b want=%b", e, clk4, ((e % 4) == 0));
            end
            if (y4 === 1'b1)   y_cycles++;
            if (clk4 === 1'b1) clk_pulses++;
        end
        total++;
        if (y_cycles != 4) begin
            bad++;
            $display("FAIL div_y_cycles got=%0d want=4", y_cycles);
        end
        total++;
        if (clk_pulses != 4) begin
            bad++;
            $display("FAIL div_clk_pulses got=%0d want=4", clk_pulses);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset1 = 1'b1;
        reset4 = 1'b1;
        x1     = 1'b0;
        x4     = 1'b0;
        #2;
        test_reset();
        test_basic_detect();
        test_back_to_back();
        test_non_patterns();
        test_mid_reset();
        test_divider();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
